// File: rtl/regfile_port_ctrl_pkg.sv
// rtl/regfile_port_ctrl_pkg.sv - widths, PC register index, requester ids and round-robin pick
package regfile_ctrl_pkg;

  localparam int RF_ADDR_WIDTH = 3;
  localparam int RF_DATA_WIDTH = 16;
  localparam int PC_REG        = 7;
  localparam int REQ_ALU       = 0;
  localparam int REQ_MEM       = 1;

  // ptr selects the contention winner: 0 = ALU, 1 = MEM
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    if (req == 2'b11) begin
      return ptr ? 2'b10 : 2'b01;
    end
    return req;
  endfunction

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// rtl/regfile_port_ctrl_if.sv - ALU and memory writeback channels into the register-file write port
interface regfile_port_ctrl_if import regfile_ctrl_pkg::*; #(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) ();

  logic                  alu_wr_valid;
  logic                  alu_wr_ready;
  logic [ADDR_WIDTH-1:0] alu_wr_addr;
  logic [DATA_WIDTH-1:0] alu_wr_data;
  logic                  mem_wr_valid;
  logic                  mem_wr_ready;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  modport master (
    output alu_wr_valid, alu_wr_addr, alu_wr_data,
    output mem_wr_valid, mem_wr_addr, mem_wr_data,
    input  alu_wr_ready, mem_wr_ready
  );

  modport slave (
    input  alu_wr_valid, alu_wr_addr, alu_wr_data,
    input  mem_wr_valid, mem_wr_addr, mem_wr_data,
    output alu_wr_ready, mem_wr_ready
  );

endinterface

// File: rtl/regfile_port_ctrl_rr_arb2.sv
// rtl/regfile_port_ctrl_rr_arb2.sv - two-request round-robin arbiter, one-hot grant, pointer to contention winner
module rr_arb2 import regfile_ctrl_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam logic PTR_ALU = 1'b0;

  logic ptr_q, ptr_d;

  // grants are suppressed while reset is held so nothing is consumed
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (!rst) begin
      gnt = rr_pick(req, ptr_q);
      if (req == 2'b11) begin
        ptr_d = ~ptr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PTR_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// rtl/regfile_port_ctrl.sv - write-port arbiter, pend scoreboard and issue hazard check for the 8-entry file
// REGFILE_BYPASS_EN adds byp1_hit/byp2_hit/byp_data and lets forwarded sources skip the stall.
module regfile_port_ctrl import regfile_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  regfile_port_ctrl_if.slave           wb,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_src1,
  input  logic [ADDR_WIDTH-1:0]        iss_src2,
  input  logic [ADDR_WIDTH-1:0]        iss_dst,
  input  logic                         iss_dst_en,
  output logic                         iss_stall,
  output logic                         rf_wr,
  output logic [ADDR_WIDTH-1:0]        rf_addr3,
  output logic [DATA_WIDTH-1:0]        rf_write_data,
  output logic [(1<<ADDR_WIDTH)-1:0]   pend,
`ifdef REGFILE_BYPASS_EN
  output logic                         byp1_hit,
  output logic                         byp2_hit,
  output logic [DATA_WIDTH-1:0]        byp_data,
`endif
  output logic                         err
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(PC_REG);

  logic [1:0]            req, gnt;
  logic                  rf_wr_q, rf_wr_d;
  logic [ADDR_WIDTH-1:0] rf_addr3_q, rf_addr3_d;
  logic [DATA_WIDTH-1:0] rf_write_data_q, rf_write_data_d;
  logic [NUM_REGS-1:0]   pend_q, pend_d, set_vec, clr_vec;
  logic                  err_q, err_d;
  logic                  wr_fire, wr_to_pc, iss_acc;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  byp1, byp2;

  assign req[REQ_ALU] = wb.alu_wr_valid;
  assign req[REQ_MEM] = wb.mem_wr_valid;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign wb.alu_wr_ready = gnt[REQ_ALU];
  assign wb.mem_wr_ready = gnt[REQ_MEM];

`ifdef REGFILE_BYPASS_EN
  assign byp1     = rf_wr_q && (rf_addr3_q == iss_src1);
  assign byp2     = rf_wr_q && (rf_addr3_q == iss_src2);
  assign byp1_hit = byp1;
  assign byp2_hit = byp2;
  assign byp_data = rf_write_data_q;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // the destination check is never bypassed: WAW must wait for the older write to land
  assign iss_stall = iss_valid && ((pend_q[iss_src1] && !byp1) ||
                                   (pend_q[iss_src2] && !byp2) ||
                                   (iss_dst_en && pend_q[iss_dst]));

  always_comb begin
    wr_fire  = |gnt;
    wr_addr  = gnt[REQ_MEM] ? wb.mem_wr_addr : wb.alu_wr_addr;
    wr_data  = gnt[REQ_MEM] ? wb.mem_wr_data : wb.alu_wr_data;
    wr_to_pc = (wr_addr == PC_ADDR);
    iss_acc  = iss_valid && !iss_stall;

    set_vec = '0;
    clr_vec = '0;
    if (iss_acc && iss_dst_en && (iss_dst != PC_ADDR)) begin
      set_vec[iss_dst] = 1'b1;
    end
    if (rf_wr_q) begin
      clr_vec[rf_addr3_q] = 1'b1;
    end
    pend_d = (pend_q & ~clr_vec) | set_vec;

    rf_wr_d         = wr_fire && !wr_to_pc;
    rf_addr3_d      = rf_wr_d ? wr_addr : rf_addr3_q;
    rf_write_data_d = rf_wr_d ? wr_data : rf_write_data_q;

    err_d = err_q
          | (wr_fire && wr_to_pc)
          | (rf_wr_d && !pend_q[wr_addr])
          | (iss_acc && iss_dst_en && (iss_dst == PC_ADDR))
          | (|(set_vec & clr_vec));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_q         <= 1'b0;
      rf_addr3_q      <= '0;
      rf_write_data_q <= '0;
      pend_q          <= '0;
      err_q           <= 1'b0;
    end else begin
      rf_wr_q         <= rf_wr_d;
      rf_addr3_q      <= rf_addr3_d;
      rf_write_data_q <= rf_write_data_d;
      pend_q          <= pend_d;
      err_q           <= err_d;
    end
  end

  assign rf_wr         = rf_wr_q;
  assign rf_addr3      = rf_addr3_q;
  assign rf_write_data = rf_write_data_q;
  assign pend          = pend_q;
  assign err           = err_q;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb/tb_regfile_port_ctrl.sv - directed scenarios plus random traffic against a behavioural scoreboard model
`timescale 1ns/1ps
module tb_regfile_port_ctrl;
  import regfile_ctrl_pkg::*;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int NR = 8;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

  logic          iss_valid, iss_dst_en;
  logic [AW-1:0] iss_src1, iss_src2, iss_dst;
  logic          iss_stall, rf_wr, err;
  logic [AW-1:0] rf_addr3;
  logic [DW-1:0] rf_write_data;
  logic [NR-1:0] pend;
`ifdef REGFILE_BYPASS_EN
  logic          byp1_hit, byp2_hit;
  logic [DW-1:0] byp_data;
`endif

  regfile_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb            (wb),
    .iss_valid     (iss_valid),
    .iss_src1      (iss_src1),
    .iss_src2      (iss_src2),
    .iss_dst       (iss_dst),
    .iss_dst_en    (iss_dst_en),
    .iss_stall     (iss_stall),
    .rf_wr         (rf_wr),
    .rf_addr3      (rf_addr3),
    .rf_write_data (rf_write_data),
    .pend          (pend),
`ifdef REGFILE_BYPASS_EN
    .byp1_hit      (byp1_hit),
    .byp2_hit      (byp2_hit),
    .byp_data      (byp_data),
`endif
    .err           (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: pending writes per register, queued file write, sticky error, contention turn
  bit m_pend [NR];
  bit m_wr;
  int m_waddr;
  int m_wdata;
  bit m_err;
  int m_turn;

  bit            s_alu_rdy, s_mem_rdy, s_stall, s_rf_wr, s_err;
  logic [AW-1:0] s_rf_addr;
  logic [DW-1:0] s_rf_data;
  logic [NR-1:0] s_pend;

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wr = 1'b0; m_waddr = 0; m_wdata = 0; m_err = 1'b0; m_turn = 0;
  endtask

  function automatic bit src_blocks(input int s);
    return m_pend[s] && !(BYP && m_wr && m_waddr == s);
  endfunction

  task automatic tick();
    int win, a, d;
    bit both, stall_e, accept;
    bit np [NR];
    logic [NR-1:0] pv;
    @(negedge clk);
    stall_e = iss_valid && (src_blocks(int'(iss_src1)) || src_blocks(int'(iss_src2)) ||
                            (iss_dst_en && m_pend[iss_dst]));
    both = wb.alu_wr_valid && wb.mem_wr_valid;
    if (both) win = m_turn;
    else if (wb.alu_wr_valid) win = 0;
    else if (wb.mem_wr_valid) win = 1;
    else win = -1;
    for (int i = 0; i < NR; i++) pv[i] = m_pend[i];

    s_alu_rdy = wb.alu_wr_ready; s_mem_rdy = wb.mem_wr_ready; s_stall = iss_stall;
    s_rf_wr = rf_wr; s_rf_addr = rf_addr3; s_rf_data = rf_write_data; s_pend = pend; s_err = err;

    check("stall", iss_stall, stall_e);
    check("alu_ready", wb.alu_wr_ready, win == 0);
    check("mem_ready", wb.mem_wr_ready, win == 1);
    check("rf_wr", rf_wr, m_wr);
    if (m_wr) begin
      check("rf_addr3", rf_addr3, m_waddr);
      check("rf_write_data", rf_write_data, m_wdata);
    end
    check("pend", pend, pv);
    check("err", err, m_err);
`ifdef REGFILE_BYPASS_EN
    check("byp1_hit", byp1_hit, m_wr && m_waddr == int'(iss_src1));
    check("byp2_hit", byp2_hit, m_wr && m_waddr == int'(iss_src2));
    if (m_wr) check("byp_data", byp_data, m_wdata);
`endif

    accept = iss_valid && !stall_e;
    np = m_pend;
    if (m_wr) np[m_waddr] = 1'b0;
    if (accept && iss_dst_en) begin
      if (iss_dst == AW'(PC_REG)) m_err = 1'b1;
      else begin
        if (m_wr && m_waddr == int'(iss_dst)) m_err = 1'b1;
        np[iss_dst] = 1'b1;
      end
    end
    if (win >= 0) begin
      a = (win == 0) ? int'(wb.alu_wr_addr) : int'(wb.mem_wr_addr);
      d = (win == 0) ? int'(wb.alu_wr_data) : int'(wb.mem_wr_data);
      if (a == PC_REG) begin
        m_err = 1'b1;
        m_wr  = 1'b0;
      end else begin
        if (!m_pend[a]) m_err = 1'b1;
        m_wr = 1'b1; m_waddr = a; m_wdata = d;
      end
    end else begin
      m_wr = 1'b0;
    end
    if (both) m_turn = 1 - win;
    m_pend = np;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_dst_en = 1'b0; iss_src1 = '0; iss_src2 = '0; iss_dst = '0;
    wb.alu_wr_valid = 1'b0; wb.alu_wr_addr = '0; wb.alu_wr_data = '0;
    wb.mem_wr_valid = 1'b0; wb.mem_wr_addr = '0; wb.mem_wr_data = '0;
  endtask

  task automatic do_issue(input int s1, input int s2, input int dst, input bit en);
    bit ok = 1'b0;
    iss_src1 = AW'(s1); iss_src2 = AW'(s2); iss_dst = AW'(dst); iss_dst_en = en; iss_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!s_stall) begin ok = 1'b1; break; end
    end
    check("issue_accept", ok, 1'b1);
    iss_valid = 1'b0;
  endtask

  task automatic do_write(input int r, input int a, input int d);
    bit ok = 1'b0;
    if (r == REQ_ALU) begin
      wb.alu_wr_valid = 1'b1; wb.alu_wr_addr = AW'(a); wb.alu_wr_data = DW'(d);
    end else begin
      wb.mem_wr_valid = 1'b1; wb.mem_wr_addr = AW'(a); wb.mem_wr_data = DW'(d);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((r == REQ_ALU) ? s_alu_rdy : s_mem_rdy) begin ok = 1'b1; break; end
    end
    check("write_grant", ok, 1'b1);
    wb.alu_wr_valid = 1'b0;
    wb.mem_wr_valid = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int q[$];
    for (int i = 0; i < NR; i++) if (m_pend[i]) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 3) != 0) return AW'(q[$urandom_range(0, q.size() - 1)]);
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int order[$];
    int alu_cnt, mem_cnt;

    rst = 1'b1;
    idle_inputs();
    model_reset();
    wb.alu_wr_valid = 1'b1;
    #12;
    check("reset_rf_wr", rf_wr, 1'b0);
    check("reset_rf_addr3", rf_addr3, 0);
    check("reset_rf_data", rf_write_data, 0);
    check("reset_pend", pend, 0);
    check("reset_err", err, 1'b0);
    check("reset_alu_ready", wb.alu_wr_ready, 1'b0);
    wb.alu_wr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // RAW on R3 resolved by an ALU write
    do_issue(0, 1, 3, 1'b1);
    tick();
    check("t1_pend_r3", s_pend, 8'h08);
    iss_src1 = 3'd3; iss_src2 = 3'd0; iss_dst_en = 1'b0; iss_valid = 1'b1;
    tick();
    check("t1_raw_stall", s_stall, 1'b1);
    wb.alu_wr_valid = 1'b1; wb.alu_wr_addr = 3'd3; wb.alu_wr_data = 16'h1234;
    tick();
    check("t1_alu_grant", s_alu_rdy, 1'b1);
    wb.alu_wr_valid = 1'b0;
    tick();
    check("t1_rf_wr", s_rf_wr, 1'b1);
    check("t1_rf_addr", s_rf_addr, 3);
    check("t1_rf_data", s_rf_data, 16'h1234);
    check("t1_stall_on_wr", s_stall, !BYP);
    tick();
    check("t1_pend_clear", s_pend, 8'h00);
    check("t1_stall_drop", s_stall, 1'b0);
    iss_valid = 1'b0;

    // simultaneous ALU/MEM writes, pointer at ALU
    do_issue(0, 0, 1, 1'b1);
    do_issue(0, 0, 2, 1'b1);
    wb.alu_wr_valid = 1'b1; wb.alu_wr_addr = 3'd1; wb.alu_wr_data = 16'hAAAA;
    wb.mem_wr_valid = 1'b1; wb.mem_wr_addr = 3'd2; wb.mem_wr_data = 16'h5555;
    tick();
    check("t2_alu_first", s_alu_rdy, 1'b1);
    check("t2_mem_waits", s_mem_rdy, 1'b0);
    wb.alu_wr_valid = 1'b0;
    tick();
    check("t2_mem_second", s_mem_rdy, 1'b1);
    check("t2_wr1_addr", s_rf_addr, 1);
    check("t2_wr1_data", s_rf_data, 16'hAAAA);
    wb.mem_wr_valid = 1'b0;
    tick();
    check("t2_wr2", s_rf_wr, 1'b1);
    check("t2_wr2_addr", s_rf_addr, 2);
    check("t2_wr2_data", s_rf_data, 16'h5555);
    tick();

    // WAW on R4
    do_issue(0, 0, 4, 1'b1);
    iss_src1 = 3'd0; iss_src2 = 3'd0; iss_dst = 3'd4; iss_dst_en = 1'b1; iss_valid = 1'b1;
    tick();
    check("t5_waw_stall", s_stall, 1'b1);
    wb.alu_wr_valid = 1'b1; wb.alu_wr_addr = 3'd4; wb.alu_wr_data = 16'h0444;
    tick();
    wb.alu_wr_valid = 1'b0;
    tick();
    check("t5_stall_while_landing", s_stall, 1'b1);
    tick();
    check("t5_accepted", s_stall, 1'b0);
    iss_valid = 1'b0;
    tick();
    check("t5_pend_r4", s_pend, 8'h10);
    do_write(REQ_ALU, 4, 16'h0555);
    tick();
    tick();
    check("t5_err_clean", s_err, 1'b0);

    // MEM write to the PC register is swallowed and flagged
    wb.mem_wr_valid = 1'b1; wb.mem_wr_addr = 3'd7; wb.mem_wr_data = 16'h00FF;
    tick();
    check("t4_mem_ready", s_mem_rdy, 1'b1);
    wb.mem_wr_valid = 1'b0;
    tick();
    check("t4_no_rf_wr", s_rf_wr, 1'b0);
    check("t4_err_set", s_err, 1'b1);
    repeat (3) tick();
    check("t4_err_sticky", s_err, 1'b1);

    // reset with pend=0x30 and a write in flight
    do_issue(0, 0, 4, 1'b1);
    do_issue(0, 0, 5, 1'b1);
    wb.alu_wr_valid = 1'b1; wb.alu_wr_addr = 3'd4; wb.alu_wr_data = 16'hBEEF;
    tick();
    wb.alu_wr_valid = 1'b0;
    check("rst_pre_rf_wr", rf_wr, 1'b1);
    check("rst_pre_pend", pend, 8'h30);
    wb.alu_wr_valid = 1'b1; wb.mem_wr_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_rf_wr", rf_wr, 1'b0);
    check("rst_rf_addr3", rf_addr3, 0);
    check("rst_rf_data", rf_write_data, 0);
    check("rst_pend", pend, 0);
    check("rst_err", err, 1'b0);
    check("rst_alu_ready", wb.alu_wr_ready, 1'b0);
    check("rst_mem_ready", wb.mem_wr_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // both requesters busy for 6 writes each: strict alternation starting at ALU
    alu_cnt = 0; mem_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      wb.alu_wr_valid = (alu_cnt < 6);
      wb.alu_wr_addr  = AW'(1 + alu_cnt % 3);
      wb.alu_wr_data  = DW'(16'hA000 + alu_cnt);
      wb.mem_wr_valid = (mem_cnt < 6);
      wb.mem_wr_addr  = AW'(4 + mem_cnt % 3);
      wb.mem_wr_data  = DW'(16'hB000 + mem_cnt);
      tick();
      if (s_alu_rdy) begin order.push_back(0); alu_cnt++; end
      if (s_mem_rdy) begin order.push_back(1); mem_cnt++; end
      if (alu_cnt >= 6 && mem_cnt >= 6) break;
    end
    wb.alu_wr_valid = 1'b0;
    wb.mem_wr_valid = 1'b0;
    check("t3_grant_count", order.size(), 12);
    for (int i = 0; i < 12 && i < order.size(); i++) check("t3_alternate", order[i], i % 2);
    repeat (2) tick();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      iss_valid  = ($urandom_range(0, 1) == 1);
      iss_src1   = AW'($urandom_range(0, 7));
      iss_src2   = AW'($urandom_range(0, 7));
      iss_dst    = AW'($urandom_range(0, 7));
      iss_dst_en = ($urandom_range(0, 2) != 0);
      if (wb.alu_wr_valid) begin
        if ($urandom_range(0, 7) == 0) wb.alu_wr_valid = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        wb.alu_wr_valid = 1'b1; wb.alu_wr_addr = pick_addr(); wb.alu_wr_data = DW'($urandom);
      end
      if (wb.mem_wr_valid) begin
        if ($urandom_range(0, 7) == 0) wb.mem_wr_valid = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        wb.mem_wr_valid = 1'b1; wb.mem_wr_addr = pick_addr(); wb.mem_wr_data = DW'($urandom);
      end
      tick();
      if (s_alu_rdy) wb.alu_wr_valid = 1'b0;
      if (s_mem_rdy) wb.mem_wr_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Write-port arbiter and hazard scoreboard for the 8-entry register file. Two writeback requesters, ALU and memory, share the single register-file write port through a round-robin valid/ready arbiter. A per-register pending scoreboard stalls the issue stage on RAW and WAW hazards until the producing write has landed. R7 is the dedicated PC register; the file loads it every clock, so requester writes to R7 are refused.

## Interface
- DATA_WIDTH, 16, register data width
- ADDR_WIDTH, 3, register address width; NUM_REGS = 1 << ADDR_WIDTH
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_wr_valid / alu_wr_ready  in/out  1  ALU writeback handshake
- alu_wr_addr  in  ADDR_WIDTH  ALU destination register
- alu_wr_data  in  DATA_WIDTH  ALU result
- mem_wr_valid / mem_wr_ready  in/out  1  memory (load) writeback handshake
- mem_wr_addr  in  ADDR_WIDTH  load destination register
- mem_wr_data  in  DATA_WIDTH  load data
- iss_valid  in  1  issue stage presents an instruction
- iss_src1, iss_src2  in  ADDR_WIDTH  source registers (always checked)
- iss_dst  in  ADDR_WIDTH  destination register
- iss_dst_en  in  1  instruction writes iss_dst
- iss_stall  out  1  combinational hold request to issue stage
- rf_wr  out  1  register-file write enable, registered
- rf_addr3  out  ADDR_WIDTH  register-file write address, registered
- rf_write_data  out  DATA_WIDTH  register-file write data, registered
- pend  out  NUM_REGS  scoreboard bit vector, registered
- err  out  1  sticky protocol error flag

## Operation
- Scoreboard: pend[r]=1 means a write to r is issued but not yet in the file.
- Issue is accepted when iss_valid && !iss_stall. On acceptance with iss_dst_en and iss_dst != 7, pend[iss_dst] sets at the next edge.
- iss_stall = iss_valid && (pend[iss_src1] || pend[iss_src2] || (iss_dst_en && pend[iss_dst])).
- Arbiter: at most one grant per cycle; ready is combinational and equals grant.
  - A lone valid requester is granted.
  - When both are valid, the requester named by the rr pointer wins. The pointer moves to the loser after a contended grant.
  - Pointer reset value selects ALU.
- Granted transfer with addr != 7: rf_wr=1, rf_addr3=addr, rf_write_data=data on the next edge. On the edge where rf_wr=1, pend[rf_addr3] clears.
- Granted transfer with addr == 7: consumed (ready=1), no rf_wr pulse, err sets.
- Granted transfer to a register whose pend bit is 0: the write is still performed and err sets.
- Issue with iss_dst_en and iss_dst == 7: accepted, no pend bit set, err sets.
- Set and clear of the same pend bit in one cycle cannot occur, because WAW stalls issue. If it does occur, set wins and err sets.
- err clears only on reset.

## Timing
- Reset values: rf_wr=0, rf_addr3=0, rf_write_data=0, pend=0, err=0, rr pointer=ALU. Ready outputs are 0 while rst is high.
- Grant to rf_wr: 1 cycle. Grant to the data being readable from the file: 2 edges.
- Issue acceptance to pend visible: 1 cycle. iss_stall reflects pend of the current cycle.
- Requesters hold valid, addr and data stable until ready; dropping valid without ready is permitted (no transfer).
- Reset mid-operation: in-flight registered writes and all pend bits are discarded. Requesters re-present after reset.

## Configuration
- REGFILE_BYPASS_EN defined: adds outputs byp1_hit, byp2_hit (1 bit) and byp_data (DATA_WIDTH).
  - bypN_hit = rf_wr && rf_addr3 == iss_srcN.
  - byp_data = rf_write_data.
  - A source pend bit does not stall when its bypN_hit=1, because the value is forwarded from rf_write_data.
- REGFILE_BYPASS_EN undefined: the ports are absent and any pending source stalls until its pend bit is clear.

## Structure
- Package regfile_ctrl_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults
  - PC_REG = 7
  - requester index constants REQ_ALU=0, REQ_MEM=1
- One sub-module, rr_arb2: two-request round-robin arbiter with pointer state, grant vector out.
- The scoreboard, the issue check and the output register stay in the top module.

## Test plan
- Issue dst=R3 (src R0,R1) → pend=0x08 next cycle. Issue src1=R3 → iss_stall=1 until ALU writes R3=0x1234. rf_wr pulse carries addr 3, data 0x1234; pend returns to 0x00; stall drops the following cycle (bypass off).
- Issue two instructions, dst R1 then dst R2. ALU writes R1, mem writes R2, both valid in the same cycle → ALU granted first, mem the next cycle. Two consecutive rf_wr pulses, in that order.
- Both requesters valid continuously, 6 writes each → grants strictly alternate ALU, MEM, ALU…
- Mem write to addr 7 with data 0x00FF → mem_wr_ready=1, no rf_wr, err=1 and it stays set.
- Issue dst=R4, then issue dst=R4 again → second stalls (WAW) until the first R4 write lands.
- Assert rst with pend=0x30 and rf_wr=1 → all outputs return to reset values immediately; the first grant after reset goes to ALU.
